tap_dot_product: RTL and testbench

//  Consumes the 4-tap window produced by the left shift buffer and computes one

---
 rtl/conv_pkg.sv | 38 +++
 rtl/fx_sat_shift.sv | 31 +++
 rtl/tap_dot_product.sv | 135 +++++++++++++
 tb/tb_tap_dot_product.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types, constants and fixed-point helpers for the conv datapath stages.
package conv_pkg;

    localparam int DEF_W    = 16;
    localparam int DEF_FRAC = 12;
    localparam int ACC_W    = 2 * DEF_W + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] SEL_W0   = 3'd0;
    localparam logic [2:0] SEL_W1   = 3'd1;
    localparam logic [2:0] SEL_W2   = 3'd2;
    localparam logic [2:0] SEL_W3   = 3'd3;
    localparam logic [2:0] SEL_BIAS = 3'd4;

    // Returns {sat, data}: arithmetic shift right by FRAC, clamped to W-bit signed range.
    function automatic logic [DEF_W:0] sat_shift(input logic [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        logic [ACC_W-DEF_W:0]    hi;
        logic                    sat;
        logic [DEF_W-1:0]        data;
        shifted = $signed(acc) >>> DEF_FRAC;
        hi      = shifted[ACC_W-1:DEF_W-1];
        sat     = !((hi == '0) || (hi == '1));
        if (!sat)
            data = shifted[DEF_W-1:0];
        else if (shifted[ACC_W-1])
            data = {1'b1, {(DEF_W-1){1'b0}}};
        else
            data = {1'b0, {(DEF_W-1){1'b1}}};
        return {sat, data};
    endfunction

endpackage

// File: rtl/fx_sat_shift.sv
// Combinational fixed-point rescale: arithmetic shift right by FRAC, then clamp
// to the signed W-bit range with a flag reporting whether clamping occurred.
module fx_sat_shift
    import conv_pkg::*;
#(
    parameter int ACC_BITS = ACC_W,
    parameter int W        = DEF_W,
    parameter int FRAC     = DEF_FRAC
) (
    input  logic [ACC_BITS-1:0] acc,
    output logic [W-1:0]        data,
    output logic                sat
);

    logic signed [ACC_BITS-1:0] shifted;
    logic [ACC_BITS-W:0]        hi;

    // In range iff every bit above the result's sign bit matches that sign bit.
    always_comb begin
        shifted = $signed(acc) >>> FRAC;
        hi      = shifted[ACC_BITS-1:W-1];
        sat     = !((hi == '0) || (hi == '1));
        if (!sat)
            data = shifted[W-1:0];
        else if (shifted[ACC_BITS-1])
            data = {1'b1, {(W-1){1'b0}}};
        else
            data = {1'b0, {(W-1){1'b1}}};
    end

endmodule

// File: rtl/tap_dot_product.sv
// One dilated causal conv output per 4-tap window: sat(bias + sum w[k]*tap[k]),
// computed with a single multiplier stepped over the taps, valid/ready on both sides.
module tap_dot_product
    import conv_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int FRAC = DEF_FRAC
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [4*W-1:0] tap,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           wr_en,
    input  logic [2:0]     wr_sel,
    input  logic [W-1:0]   wr_data,
    output logic           wr_ready,
    output logic [W-1:0]   out_data,
    output logic           out_sat,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int AW = 2 * W + 3;

    state_t state, state_nxt;

    logic signed [W-1:0]   coef_w [4];
    logic signed [W-1:0]   bias;
    logic signed [W-1:0]   w_snap [4];
    logic signed [W-1:0]   tap_q  [4];
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  acc_nxt;
    logic signed [2*W-1:0] prod;
    logic [1:0]            idx;
    logic [W-1:0]          res_data;
    logic                  res_sat;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = MAC;
            MAC:     if (idx == 2'd3) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        wr_ready = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned k = 0; k < 4; k++)
                coef_w[k] <= '0;
            bias <= '0;
        end else if (wr_en && wr_ready) begin
            case (wr_sel)
                SEL_W0:   coef_w[0] <= wr_data;
                SEL_W1:   coef_w[1] <= wr_data;
                SEL_W2:   coef_w[2] <= wr_data;
                SEL_W3:   coef_w[3] <= wr_data;
                SEL_BIAS: bias      <= wr_data;
                default:  ;
            endcase
        end
    end

    assign prod    = w_snap[idx] * tap_q[idx];
    assign acc_nxt = acc + {{(AW-2*W){prod[2*W-1]}}, prod};

    // Fed with acc_nxt so the result registers on the same edge as the last MAC step.
    fx_sat_shift #(
        .ACC_BITS (AW),
        .W        (W),
        .FRAC     (FRAC)
    ) u_sat (
        .acc  (acc_nxt),
        .data (res_data),
        .sat  (res_sat)
    );

    // Weights are snapshotted with the taps so a same-cycle coefficient write
    // only takes effect from the following window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc       <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
            for (int unsigned k = 0; k < 4; k++) begin
                tap_q[k]  <= '0;
                w_snap[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned k = 0; k < 4; k++) begin
                            tap_q[k]  <= tap[k*W +: W];
                            w_snap[k] <= coef_w[k];
                        end
                        acc <= {{(AW-W){bias[W-1]}}, bias} << FRAC;
                        idx <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_nxt;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        out_data  <= res_data;
                        out_sat   <= res_sat;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tap_dot_product.sv
// Directed vector bench for tap_dot_product: table of coefficient/tap sets with
// hand-computed results, plus backpressure, reset-abort and same-cycle-write sequences.
module tb_tap_dot_product;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] tap = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_sel = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    tap_dot_product #(
        .W    (16),
        .FRAC (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tap       (tap),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] w0, w1, w2, w3, b;
        logic [15:0] t0, t1, t2, t3;
        logic [15:0] ed;
        logic        es;
    } vec_t;

    vec_t vecs [13];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] sel, input logic [15:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic load(input logic [15:0] w0, w1, w2, w3, b);
        wr(3'd0, w0); wr(3'd1, w1); wr(3'd2, w2); wr(3'd3, w3); wr(3'd4, b);
    endtask

    task automatic start(input string name, input logic [15:0] t0, t1, t2, t3);
        tap = {t3, t2, t1, t0};
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        check({name, " busy"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic finish_window(input string name, input logic [15:0] ed, input logic es);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick;
            lat++;
        end
        check({name, " latency"}, lat, 32'd4);
        check({name, " data"}, {16'd0, out_data}, {16'd0, ed});
        check({name, " sat"}, {31'd0, out_sat}, {31'd0, es});
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({name, " drained"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        vecs[0]  = '{16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A, 1'b0};
        vecs[1]  = '{16'h1000, 16'hF000, 16'h0800, 16'h0000, 16'h0000, 16'h2000, 16'h1000, 16'h2000, 16'h7FFF, 16'h2000, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
        vecs[3]  = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 1'b1};
        vecs[4]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0800, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0800, 1'b0};
        vecs[5]  = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 1'b0};
        vecs[6]  = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hEFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 1'b0};
        vecs[7]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h7FFF, 1'b0};
        vecs[8]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h8000, 1'b0};
        vecs[9]  = '{16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 1'b1};
        vecs[10] = '{16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 1'b1};
        vecs[11] = '{16'h0000, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h8000, 16'h4321, 16'h7777, 16'h7FFF, 1'b1};
        vecs[12] = '{16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'h5555, 16'h6666, 16'h7777, 16'h0123, 16'h0123, 1'b0};

        rst = 1'b0;
        tick; tick;
        rst = 1'b1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset ready", {30'd0, in_ready, wr_ready}, 32'd3);
        check("reset out_data", {16'd0, out_data}, 32'd0);
        check("reset out_sat", {31'd0, out_sat}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            load(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3, vecs[i].b);
            start($sformatf("vec%0d", i), vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].t3);
            finish_window($sformatf("vec%0d", i), vecs[i].ed, vecs[i].es);
        end

        // Backpressure: result held, inputs and coefficient writes ignored while busy.
        load(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0000);
        start("hold", 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        seen = 0;
        while (!out_valid && seen < 20) begin
            tick;
            seen++;
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            wr_en = 1'b1; wr_sel = 3'd4; wr_data = 16'h7000;
            tap = {4{16'h0100}};
            tick;
            check("hold out_data", {16'd0, out_data}, 32'h000A);
            check("hold flags", {29'd0, out_valid, in_ready, wr_ready}, 32'd4);
        end
        in_valid = 1'b0; wr_en = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("hold release", {30'd0, out_valid, in_ready}, 32'd1);
        start("hold rerun", 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        finish_window("hold rerun", 16'h000A, 1'b0);

        // Same-cycle write and accept: the accepted window uses pre-write coefficients.
        tap = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        in_valid = 1'b1; wr_en = 1'b1; wr_sel = 3'd4; wr_data = 16'h0100;
        tick;
        in_valid = 1'b0; wr_en = 1'b0;
        finish_window("samecyc bias", 16'h000A, 1'b0);
        in_valid = 1'b1; wr_en = 1'b1; wr_sel = 3'd0; wr_data = 16'h2000;
        tick;
        in_valid = 1'b0; wr_en = 1'b0;
        finish_window("samecyc w0", 16'h010A, 1'b0);
        start("samecyc after", 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        finish_window("samecyc after", 16'h010B, 1'b0);

        // Reset mid-MAC: computation aborted, coefficients cleared.
        load(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0000);
        start("abort", 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen++;
            tick;
        end
        check("abort no result", seen, 32'd0);
        start("abort rerun", 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        finish_window("abort rerun", 16'h0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
